// File: rtl/multicycle_control_if.sv
// multicycle_control_if: decode fields, memory handshake and datapath control between the control FSM and the datapath
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       read_reg_flag;
    logic       write_reg_flag;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;
    logic       mem_fault;
    logic [3:0] state;
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               read_reg_flag, write_reg_flag, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, illegal_op, mem_fault, state
    );
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_source,
               read_reg_flag, write_reg_flag, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, illegal_op, mem_fault, state
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM (R-type, addi, lw, sw, beq, j) with memory-wait timeout
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3,
        MEM_WB = 4'd4, MEM_WR = 4'd5, R_EX = 4'd6, R_WB = 4'd7,
        BEQ = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11
    } state_t;
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
    state_t st, nx;
    logic [7:0] cnt;
    logic wait_st, fault, r_ok;
    assign wait_st = st inside {FETCH, MEM_RD, MEM_WR};
    assign fault = wait_st && !bus.mem_ready && cnt == TMO;
    assign r_ok = bus.opcode == 6'h00 && bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    assign bus.state = st;
    // counter only survives a cycle spent stalled in a wait state
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st  <= nx;
            cnt <= (wait_st && !bus.mem_ready && !fault) ? cnt + 8'd1 : '0;
        end
    end
    always_comb begin
        nx = st;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.i_or_d = 1'b0;
        bus.ir_write = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_source = 2'd0;
        bus.read_reg_flag = 1'b0;
        bus.write_reg_flag = 1'b0;
        bus.reg_dst = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'd0;
        bus.alu_op = 2'd0;
        bus.illegal_op = 1'b0;
        bus.mem_fault = 1'b0;
        if (!reset) begin
            case (st)
                FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                    nx = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.read_reg_flag = 1'b1;
                    bus.alu_src_b = 2'd3;
                    nx = (bus.opcode == 6'h23 || bus.opcode == 6'h2B) ? MEM_ADDR :
                         r_ok                  ? R_EX    :
                         bus.opcode == 6'h08   ? ADDI_EX :
                         bus.opcode == 6'h04   ? BEQ     :
                         bus.opcode == 6'h02   ? JUMP    : FETCH;
                    bus.illegal_op = nx == FETCH;
                end
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    nx = bus.opcode == 6'h2B ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d = 1'b1;
                    nx = bus.mem_ready ? MEM_WB : fault ? FETCH : MEM_RD;
                end
                MEM_WB: begin
                    bus.write_reg_flag = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    nx = FETCH;
                end
                MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.i_or_d = 1'b1;
                    nx = (bus.mem_ready || fault) ? FETCH : MEM_WR;
                end
                R_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op = 2'd2;
                    nx = R_WB;
                end
                R_WB: begin
                    bus.write_reg_flag = 1'b1;
                    bus.reg_dst = 1'b1;
                    nx = FETCH;
                end
                ADDI_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    nx = ADDI_WB;
                end
                ADDI_WB: begin
                    bus.write_reg_flag = 1'b1;
                    nx = FETCH;
                end
                BEQ: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op = 2'd1;
                    bus.pc_source = 2'd1;
                    bus.pc_write = bus.zero;
                    nx = FETCH;
                end
                JUMP: begin
                    bus.pc_source = 2'd2;
                    bus.pc_write = 1'b1;
                    nx = FETCH;
                end
                default: nx = FETCH;
            endcase
            bus.mem_fault = fault;
        end
    end
endmodule
